// File: rtl/pkg_cpu_types.sv
// rtl/pkg_cpu_types.sv - IO window base and register offsets shared by the MMIO bridge
package pkg_cpu_types;

   localparam logic [13:0] IO_BASE_DEFAULT = 14'h3F00;
   localparam logic [13:0] IO_SPAN         = 14'h00FF;

   typedef enum logic [7:0] {
      IO_START = 8'h00,
      IO_DONE  = 8'h01,
      IO_BUSY  = 8'h02,
      IO_CYCLE = 8'h03,
      IO_H2F   = 8'h04,
      IO_F2H   = 8'h08
   } io_reg_t;

   localparam int OFF_H2F = 4;
   localparam int OFF_F2H = 8;

endpackage

// File: rtl/done_tracker.sv
// rtl/done_tracker.sv - per-accelerator busy/sticky-done tracking from start writes and done edges
module done_tracker #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_we,
   input  logic [W-1:0] start_mask,
   input  logic         clr_we,
   input  logic [W-1:0] clr_mask,
   input  logic [W-1:0] done_in,
   output logic [W-1:0] busy,
   output logic [W-1:0] done
);

   logic [W-1:0] done_prev;
   logic [W-1:0] rise;
   logic [W-1:0] set_busy;
   logic [W-1:0] clr_done;

   assign rise     = done_in & ~done_prev;
   assign set_busy = start_we ? start_mask : '0;
   assign clr_done = clr_we ? clr_mask : '0;

   // a new start outranks a finishing edge for BUSY; a finishing edge outranks W1C for DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         done_prev <= '0;
         busy      <= '0;
         done      <= '0;
      end else begin
         done_prev <= done_in;
         busy      <= (busy & ~rise) | set_busy;
         done      <= (done & ~clr_done) | rise;
      end
   end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU data-port split between data RAM and an accelerator IO window
module mmio_bridge
   import pkg_cpu_types::*;
#(
   parameter int          N_MBOX  = 4,
   parameter logic [13:0] IO_BASE = IO_BASE_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [13:0]            cpu_addr,
   input  logic                   cpu_we,
   input  logic [31:0]            cpu_wd,
   output logic [31:0]            cpu_rd,
   output logic [13:0]            ram_addr,
   output logic                   ram_we,
   output logic [31:0]            ram_wd,
   input  logic [31:0]            ram_rd,
   output logic [31:0]            start_io,
   input  logic [31:0]            done_io,
   input  logic [N_MBOX-1:0][31:0] h2f_io,
   output logic [N_MBOX-1:0][31:0] f2h_io,
   input  logic                   ebreak,
   output logic                   halted
);

   logic [13:0] addr_off;
   logic [7:0]  off;
   logic [31:0] off_w;
   logic        in_io;
   logic        wr_ok;
   logic        io_we;
   logic        start_we;
   logic        done_we;
   logic [31:0] busy;
   logic [31:0] done;
   logic [31:0] cycle;
   logic [31:0] io_rd_d;
   logic [31:0] io_rd_q;
   logic        io_sel_q;

   // unsigned distance from the base doubles as the window test
   assign addr_off = cpu_addr - IO_BASE;
   assign in_io    = (addr_off <= IO_SPAN);
   assign off      = addr_off[7:0];
   assign off_w    = {24'd0, off};

   // stores are dropped in reset and once the CPU has halted
   assign wr_ok    = cpu_we && !halted && !rst;
   assign io_we    = wr_ok && in_io;
   assign start_we = io_we && (off == IO_START);
   assign done_we  = io_we && (off == IO_DONE);

   assign ram_addr = cpu_addr;
   assign ram_wd   = cpu_wd;
   assign ram_we   = wr_ok && !in_io;

   done_tracker #(.W(32)) u_done_tracker (
      .clk        (clk),
      .rst        (rst),
      .start_we   (start_we),
      .start_mask (cpu_wd),
      .clr_we     (done_we),
      .clr_mask   (cpu_wd),
      .done_in    (done_io),
      .busy       (busy),
      .done       (done)
   );

   // IO register read mux; START and unmapped offsets read as zero
   always_comb begin
      io_rd_d = '0;
      case (off)
         IO_DONE:  io_rd_d = done;
         IO_BUSY:  io_rd_d = busy;
         IO_CYCLE: io_rd_d = cycle;
         default:  io_rd_d = '0;
      endcase
      for (int k = 0; k < N_MBOX; k++) begin
         if (off_w == 32'(OFF_H2F + k)) io_rd_d = h2f_io[k];
         if (off_w == 32'(OFF_F2H + k)) io_rd_d = f2h_io[k];
      end
   end

   // read registers give both regions the same one-cycle load latency
   always_ff @(posedge clk) begin
      if (rst) begin
         io_sel_q <= 1'b0;
         io_rd_q  <= '0;
      end else begin
         io_sel_q <= in_io;
         io_rd_q  <= io_rd_d;
      end
   end

   assign cpu_rd = io_sel_q ? io_rd_q : ram_rd;

   // start pulse, free-running cycle counter and sticky halt
   always_ff @(posedge clk) begin
      if (rst) begin
         start_io <= '0;
         cycle    <= '0;
         halted   <= 1'b0;
      end else begin
         start_io <= start_we ? cpu_wd : '0;
         if (!halted) cycle <= cycle + 32'd1;
         if (ebreak)  halted <= 1'b1;
      end
   end

   // fabric-bound mailbox words written by CPU stores
   always_ff @(posedge clk) begin
      if (rst) begin
         f2h_io <= '0;
      end else begin
         for (int k = 0; k < N_MBOX; k++) begin
            if (io_we && off_w == 32'(OFF_F2H + k)) f2h_io[k] <= cpu_wd;
         end
      end
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - self-checking bench for mmio_bridge against a behavioural model
module tb_mmio_bridge;

   localparam int NMB = 4;
   localparam int IOB = 'h3F00;

   logic                clk = 1'b0;
   logic                rst;
   logic [13:0]         cpu_addr;
   logic                cpu_we;
   logic [31:0]         cpu_wd;
   logic [31:0]         cpu_rd;
   logic [13:0]         ram_addr;
   logic                ram_we;
   logic [31:0]         ram_wd;
   logic [31:0]         ram_rd;
   logic [31:0]         start_io;
   logic [31:0]         done_io;
   logic [NMB-1:0][31:0] h2f_io;
   logic [NMB-1:0][31:0] f2h_io;
   logic                ebreak;
   logic                halted;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram_mem [0:16383];
   logic [31:0] ref_mem [0:16383];

   logic [31:0] m_busy, m_done, m_prev, m_cycle, m_start, m_rd;
   logic        m_halted;
   logic [31:0] m_f2h [NMB];

   always #5 clk = ~clk;

   mmio_bridge #(.N_MBOX(NMB), .IO_BASE(14'h3F00)) dut (
      .clk      (clk),
      .rst      (rst),
      .cpu_addr (cpu_addr),
      .cpu_we   (cpu_we),
      .cpu_wd   (cpu_wd),
      .cpu_rd   (cpu_rd),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_wd   (ram_wd),
      .ram_rd   (ram_rd),
      .start_io (start_io),
      .done_io  (done_io),
      .h2f_io   (h2f_io),
      .f2h_io   (f2h_io),
      .ebreak   (ebreak),
      .halted   (halted)
   );

   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wd;
      ram_rd <= ram_mem[ram_addr];
   end

   function automatic logic m_is_io(logic [13:0] a);
      return (int'(a) >= IOB) && (int'(a) <= IOB + 255);
   endfunction

   function automatic logic [31:0] io_value(int off);
      if (off == 1) return m_done;
      if (off == 2) return m_busy;
      if (off == 3) return m_cycle;
      if (off >= 4 && off < 4 + NMB) return h2f_io[off-4];
      if (off >= 8 && off < 8 + NMB) return m_f2h[off-8];
      return 32'd0;
   endfunction

   task automatic drive(input logic [13:0] a, input logic we, input logic [31:0] wd);
      cpu_addr = a;
      cpu_we   = we;
      cpu_wd   = wd;
   endtask

   task automatic tick();
      int          off;
      logic        io;
      logic        wr;
      logic [31:0] rise;
      logic [31:0] startm;
      logic [31:0] clrm;
      io  = m_is_io(cpu_addr);
      off = int'(cpu_addr) - IOB;
      if (rst) begin
         m_rd     = ref_mem[cpu_addr];
         m_busy   = 0;
         m_done   = 0;
         m_prev   = 0;
         m_cycle  = 0;
         m_start  = 0;
         m_halted = 0;
         for (int k = 0; k < NMB; k++) m_f2h[k] = 0;
      end else begin
         wr   = cpu_we && !m_halted;
         m_rd = io ? io_value(off) : ref_mem[cpu_addr];
         if (wr && !io) ref_mem[cpu_addr] = cpu_wd;
         rise   = done_io & ~m_prev;
         startm = (wr && io && off == 0) ? cpu_wd : 32'd0;
         clrm   = (wr && io && off == 1) ? cpu_wd : 32'd0;
         m_start = startm;
         for (int i = 0; i < 32; i++) begin
            if (startm[i])     m_busy[i] = 1'b1;
            else if (rise[i])  m_busy[i] = 1'b0;
            if (rise[i])       m_done[i] = 1'b1;
            else if (clrm[i])  m_done[i] = 1'b0;
         end
         if (wr && io && off >= 8 && off < 8 + NMB) m_f2h[off-8] = cpu_wd;
         m_prev = done_io;
         if (!m_halted) m_cycle = m_cycle + 1;
         if (ebreak) m_halted = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; done_io = 0; ebreak = 0;
      for (int k = 0; k < NMB; k++) h2f_io[k] = $urandom;
      drive(14'h0020, 1, 32'hCAFE_0001);
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
      checks++; if (ram_addr !== 14'h0020) begin errors++; $display("FAIL reset_ram_addr: got %h expected 0020", ram_addr); end
      tick();
      drive(14'(IOB), 1, 32'hFFFF_FFFF);
      tick();
      checks++; if (start_io !== 32'd0) begin errors++; $display("FAIL reset_start_io: got %h expected 0", start_io); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
      for (int k = 0; k < NMB; k++) begin
         checks++; if (f2h_io[k] !== 32'd0) begin errors++; $display("FAIL reset_f2h%0d: got %h expected 0", k, f2h_io[k]); end
      end
      rst = 0;
      drive(14'(IOB + 3), 0, 0);
      tick();
      checks++; if (cpu_rd !== 32'd0) begin errors++; $display("FAIL reset_cycle_rd: got %h expected 0", cpu_rd); end
      checks++; if (start_io !== 32'd0) begin errors++; $display("FAIL reset_start_discard: got %h expected 0", start_io); end
      drive(14'(IOB + 2), 0, 0);
      tick();
      checks++; if (cpu_rd !== 32'd0) begin errors++; $display("FAIL reset_busy_rd: got %h expected 0", cpu_rd); end
   endtask

   task automatic test_start_done();
      drive(14'(IOB), 1, 32'h5);
      tick();
      checks++; if (start_io !== 32'h5) begin errors++; $display("FAIL start_pulse: got %h expected 5", start_io); end
      drive(14'(IOB + 2), 0, 0);
      tick();
      checks++; if (start_io !== 32'h0) begin errors++; $display("FAIL start_pulse_end: got %h expected 0", start_io); end
      checks++; if (cpu_rd !== 32'h5) begin errors++; $display("FAIL busy_after_start: got %h expected 5", cpu_rd); end
      done_io = 32'h4;
      tick();
      checks++; if (cpu_rd !== m_rd) begin errors++; $display("FAIL busy_edge_cycle: got %h expected %h", cpu_rd, m_rd); end
      tick();
      checks++; if (cpu_rd !== 32'h1) begin errors++; $display("FAIL busy_after_done: got %h expected 1", cpu_rd); end
      drive(14'(IOB + 1), 0, 0);
      tick();
      checks++; if (cpu_rd !== 32'h4) begin errors++; $display("FAIL done_after_done: got %h expected 4", cpu_rd); end
      drive(14'(IOB + 1), 1, 32'h4);
      tick();
      drive(14'(IOB + 1), 0, 0);
      tick();
      checks++; if (cpu_rd !== 32'h0) begin errors++; $display("FAIL done_w1c: got %h expected 0", cpu_rd); end
      done_io = 0;
      tick();
   endtask

   task automatic test_same_cycle();
      done_io = 32'h1;
      drive(14'h0001, 0, 0);
      tick();
      done_io = 32'h0;
      tick();
      done_io = 32'h1;
      drive(14'(IOB + 1), 1, 32'h1);
      tick();
      drive(14'(IOB + 1), 0, 0);
      tick();
      checks++; if (cpu_rd[0] !== 1'b1) begin errors++; $display("FAIL w1c_vs_rise: got %b expected 1", cpu_rd[0]); end
      checks++; if (cpu_rd !== m_rd) begin errors++; $display("FAIL w1c_vs_rise_word: got %h expected %h", cpu_rd, m_rd); end
      done_io = 32'h1;
      tick();
      done_io = 32'h3;
      drive(14'(IOB), 1, 32'h2);
      tick();
      drive(14'(IOB + 2), 0, 0);
      tick();
      checks++; if (cpu_rd[1] !== 1'b1) begin errors++; $display("FAIL start_vs_rise_busy: got %b expected 1", cpu_rd[1]); end
      drive(14'(IOB + 1), 0, 0);
      tick();
      checks++; if (cpu_rd[1] !== 1'b1) begin errors++; $display("FAIL start_vs_rise_done: got %b expected 1", cpu_rd[1]); end
      done_io = 0;
      tick();
   endtask

   task automatic test_mailbox();
      logic [31:0] v;
      drive(14'(IOB + 9), 1, 32'hDEAD_BEEF);
      tick();
      checks++; if (f2h_io[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL f2h_out: got %h expected deadbeef", f2h_io[1]); end
      drive(14'(IOB + 9), 0, 0);
      tick();
      checks++; if (cpu_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL f2h_load: got %h expected deadbeef", cpu_rd); end
      v = $urandom;
      h2f_io[2] = v;
      drive(14'(IOB + 6), 0, 0);
      tick();
      checks++; if (cpu_rd !== v) begin errors++; $display("FAIL h2f_load: got %h expected %h", cpu_rd, v); end
      drive(14'h3FFF, 1, 32'h1111_2222);
      tick();
      drive(14'h3FFF, 0, 0);
      tick();
      checks++; if (cpu_rd !== 32'd0) begin errors++; $display("FAIL unmapped_rd: got %h expected 0", cpu_rd); end
   endtask

   task automatic test_ram();
      drive(14'h0010, 1, 32'h1234);
      #1;
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ram_we_ram: got %b expected 1", ram_we); end
      checks++; if (ram_wd !== 32'h1234) begin errors++; $display("FAIL ram_wd: got %h expected 1234", ram_wd); end
      tick();
      drive(14'(IOB + 8), 1, 32'h55);
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_we_io: got %b expected 0", ram_we); end
      tick();
      drive(14'(IOB - 1), 1, 32'hA5A5);
      #1;
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ram_we_below_base: got %b expected 1", ram_we); end
      tick();
      drive(14'h3FFF, 1, 32'h7777);
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_we_top_io: got %b expected 0", ram_we); end
      tick();
      drive(14'h0010, 0, 0);
      tick();
      checks++; if (cpu_rd !== 32'h1234) begin errors++; $display("FAIL ram_load: got %h expected 1234", cpu_rd); end
      drive(14'(IOB - 1), 0, 0);
      tick();
      checks++; if (cpu_rd !== 32'hA5A5) begin errors++; $display("FAIL ram_load_edge: got %h expected a5a5", cpu_rd); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic [13:0] a;
         logic        exp_we;
         case ($urandom_range(0, 2))
            0:       a = 14'(IOB + $urandom_range(0, 15));
            1:       a = 14'($urandom_range(0, 31));
            default: a = 14'($urandom_range(0, 16383));
         endcase
         drive(a, 1'($urandom_range(0, 1)), $urandom);
         done_io = done_io ^ ($urandom & $urandom & $urandom);
         h2f_io[$urandom_range(0, NMB-1)] = $urandom;
         #1;
         exp_we = cpu_we && !m_is_io(a) && !m_halted;
         checks++; if (ram_we !== exp_we) begin errors++; $display("FAIL rnd_ram_we n=%0d: got %b expected %b", n, ram_we, exp_we); end
         tick();
         checks++; if (cpu_rd !== m_rd) begin errors++; $display("FAIL rnd_cpu_rd n=%0d: got %h expected %h", n, cpu_rd, m_rd); end
         checks++; if (start_io !== m_start) begin errors++; $display("FAIL rnd_start_io n=%0d: got %h expected %h", n, start_io, m_start); end
         for (int k = 0; k < NMB; k++) begin
            checks++; if (f2h_io[k] !== m_f2h[k]) begin errors++; $display("FAIL rnd_f2h%0d n=%0d: got %h expected %h", k, n, f2h_io[k], m_f2h[k]); end
         end
      end
      cpu_we  = 0;
      done_io = 0;
      tick();
   endtask

   task automatic test_halt();
      rst = 1;
      drive(14'h0000, 0, 0);
      tick();
      rst = 0;
      repeat (100) tick();
      ebreak = 1;
      drive(14'(IOB + 3), 0, 0);
      tick();
      ebreak = 0;
      checks++; if (cpu_rd !== 32'd100) begin errors++; $display("FAIL cycle_at_ebreak: got %0d expected 100", cpu_rd); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_set: got %b expected 1", halted); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (cpu_rd !== 32'd101) begin errors++; $display("FAIL cycle_frozen%0d: got %0d expected 101", i, cpu_rd); end
      end
      drive(14'h0010, 1, 32'h0BAD);
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL halted_ram_we: got %b expected 0", ram_we); end
      tick();
      drive(14'(IOB + 8), 1, 32'h0BAD);
      tick();
      checks++; if (f2h_io[0] !== 32'd0) begin errors++; $display("FAIL halted_io_write: got %h expected 0", f2h_io[0]); end
      drive(14'(IOB), 1, 32'hF);
      tick();
      checks++; if (start_io !== 32'd0) begin errors++; $display("FAIL halted_start: got %h expected 0", start_io); end
      drive(14'h0010, 0, 0);
      tick();
      checks++; if (cpu_rd !== m_rd) begin errors++; $display("FAIL halted_ram_load: got %h expected %h", cpu_rd, m_rd); end
      rst = 1;
      drive(14'h0010, 1, 32'h1);
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL final_reset_ram_we: got %b expected 0", ram_we); end
      tick();
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL final_reset_halted: got %b expected 0", halted); end
      checks++; if (start_io !== 32'd0) begin errors++; $display("FAIL final_reset_start: got %h expected 0", start_io); end
      for (int k = 0; k < NMB; k++) begin
         checks++; if (f2h_io[k] !== 32'd0) begin errors++; $display("FAIL final_reset_f2h%0d: got %h expected 0", k, f2h_io[k]); end
      end
      rst = 0;
      cpu_we = 0;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) begin
         ram_mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      m_busy = 0; m_done = 0; m_prev = 0; m_cycle = 0; m_start = 0; m_rd = 0; m_halted = 0;
      for (int k = 0; k < NMB; k++) m_f2h[k] = 0;
      rst = 1; cpu_addr = 0; cpu_we = 0; cpu_wd = 0; done_io = 0; ebreak = 0; h2f_io = '0;
      @(negedge clk);
      test_reset();
      test_start_done();
      test_same_cycle();
      test_mailbox();
      test_ram();
      test_random();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameter N_MBOX, default 4: number of 32-bit host-to-fabric and fabric-to-host mailbox words.
REQ-002 Parameter IO_BASE, default 14'h3F00: first word address of the IO window; the window spans IO_BASE to IO_BASE+14'h00FF.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cpu_addr  in  14  word address from the CPU data port.
REQ-006 cpu_we  in  1  CPU store strobe, valid for the same cycle as cpu_addr.
REQ-007 cpu_wd  in  32  CPU store data.
REQ-008 cpu_rd  out  32  load data returned to the CPU, one cycle after the address.
REQ-009 ram_addr / ram_we / ram_wd  out  14/1/32  port to the synchronous data RAM.
REQ-010 ram_rd  in  32  RAM read data, one cycle after ram_addr.
REQ-011 start_io  out  32  per-accelerator start pulses.
REQ-012 done_io  in  32  per-accelerator done levels.
REQ-013 h2f_io  in  N_MBOX x 32  host-to-fabric mailbox words.
REQ-014 f2h_io  out  N_MBOX x 32  fabric-to-host mailbox words.
REQ-015 ebreak  in  1  CPU halt request.
REQ-016 halted  out  1  sticky halt flag.

Function
REQ-017 Address decode: cpu_addr inside the IO window selects IO; any other address selects RAM.
REQ-018 RAM path: ram_addr = cpu_addr always; ram_wd = cpu_wd; ram_we = cpu_we only when RAM is selected.
REQ-019 IO register map (offsets from IO_BASE):
- 0x00 START: write-only; reads return 0.
- 0x01 DONE: sticky bits, write-1-to-clear.
- 0x02 BUSY: read-only.
- 0x03 CYCLE: read-only.
- 0x04..0x04+N_MBOX-1 H2F: read-only.
- 0x08..0x08+N_MBOX-1 F2H: read/write.
- Any other offset reads 0, and writes to it are ignored.
REQ-020 Read latency is exactly 1 cycle for both regions: the region select and IO read data are registered, and cpu_rd muxes the registered IO data against ram_rd.
REQ-021 A write to START drives start_io = cpu_wd for exactly one cycle (the cycle after the write); start_io is 0 in all other cycles.
REQ-022 A write to START sets BUSY[i] for every set bit i of cpu_wd.
REQ-023 Each rising edge of done_io[i] (registered previous value 0, current value 1) clears BUSY[i] and sets DONE[i].
REQ-024 Same bit, same cycle, START write and done rising edge: BUSY[i] ends set, and DONE[i] still sets.
REQ-025 Same bit, same cycle, W1C of DONE and done rising edge: the set wins, so DONE[i] = 1.
REQ-026 H2F reads return h2f_io sampled in the read cycle, through the read register.
REQ-027 F2H[k] is written by CPU stores, and f2h_io[k] reflects the register directly.
REQ-028 CYCLE is a 32-bit counter that increments every cycle while halted = 0, wraps 32'hFFFFFFFF to 0, and freezes while halted = 1.
REQ-029 halted sets on the cycle after ebreak = 1 and stays set until reset.
REQ-030 While halted = 1: ram_we is forced to 0, IO writes are ignored, and reads still function.

Reset
REQ-031 When rst = 1 at a clock edge, all of the following reach 0 on that edge:
- start_io, BUSY, DONE, F2H, CYCLE, halted, the read registers, and the done_io edge-history register.
REQ-032 Combinational outputs (ram_addr, ram_wd, ram_we) follow their inputs during reset, except that ram_we is forced to 0.
REQ-033 A START write that coincides with rst = 1 is discarded and produces no start_io pulse.

Structure
REQ-034 The IO_BASE default, the register offset constants and an io_reg_t offset enum shall live in pkg_cpu_types.
REQ-035 The per-bit BUSY/DONE/edge-detect logic shall be a sub-module, done_tracker, instantiated once at width 32.
REQ-036 The block shall contain no combinational path from cpu_addr to cpu_rd that bypasses the read register.

Verification
REQ-037 Store 32'h0000_0005 to IO_BASE+0x00 -> start_io = 32'h0000_0005 for exactly 1 cycle, and BUSY reads 32'h5.
REQ-038 Raise done_io[2] after that start -> BUSY reads 32'h1 and DONE reads 32'h4; then store 32'h4 to DONE -> DONE reads 0.
REQ-039 Same-cycle W1C of DONE[0] and done_io[0] rising edge -> DONE[0] reads 1.
REQ-040 Store 32'hDEAD_BEEF to F2H[1], then load it -> f2h_io[1] = 32'hDEADBEEF, and cpu_rd = 32'hDEADBEEF one cycle after the address.
REQ-041 Store 32'h1234 to word address 14'h0010 -> ram_we = 1 and ram_wd = 32'h1234; storing to IO_BASE+0x08 -> ram_we = 0.
REQ-042 Pulse ebreak at CYCLE = 100 -> halted = 1, CYCLE reads 101 on every later load, and a store to 14'h0010 gives ram_we = 0; then assert rst -> all outputs 0.
